// File: rtl/scanner_link_pkg.sv
// scanner_link_pkg
//   Definitions shared by the scanner link transmitter and receiver:
//   command codes, fill-status encodings and the receiver state enum.
package scanner_link_pkg;

  // Command frame codes
  localparam logic [7:0] CMD_READY_TO_TRANSFER = 8'd2;  // scanner at 80%
  localparam logic [7:0] CMD_START_SCANNING    = 8'd3;  // scanner at 90%
  localparam logic [7:0] CMD_BUFFER_FULL       = 8'd4;  // scanner at 100%
  localparam logic [7:0] CMD_DATA_TRANSFER     = 8'd7;  // one payload frame follows

  // fill_status encodings
  localparam logic [1:0] FILL_BELOW_80 = 2'd0;
  localparam logic [1:0] FILL_80       = 2'd1;
  localparam logic [1:0] FILL_90       = 2'd2;
  localparam logic [1:0] FILL_FULL     = 2'd3;

  // Receiver frame-decode state: expecting a command, or a payload frame
  typedef enum logic {
    S_CMD  = 1'b0,
    S_DATA = 1'b1
  } link_state_t;

endpackage

// File: rtl/link_sync_edge.sv
// link_sync_edge
//   Brings the asynchronous ser_clk/ser_data pair into the clk domain.
//   Both lines go through identical SYNC_STAGES-deep flop chains, so the
//   data bit presented alongside the edge strobe is the one that was stable
//   at the ser_clk rising edge.
// Ports:
//   clk, rst   system clock, synchronous active-high reset
//   ser_clk    link clock (async, at most clk/4)
//   ser_data   link data
//   sync_data  synchronized data bit
//   clk_rise   one-cycle strobe on a synchronized ser_clk rising edge
module link_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic ser_clk,
  input  logic ser_data,
  output logic sync_data,
  output logic clk_rise
);

  logic [SYNC_STAGES-1:0] clk_sync_reg;
  logic [SYNC_STAGES-1:0] data_sync_reg;
  logic                   clk_d_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      clk_sync_reg  <= '0;
      data_sync_reg <= '0;
      clk_d_reg     <= 1'b0;
    end else begin
      clk_sync_reg  <= {clk_sync_reg[SYNC_STAGES-2:0], ser_clk};
      data_sync_reg <= {data_sync_reg[SYNC_STAGES-2:0], ser_data};
      clk_d_reg     <= clk_sync_reg[SYNC_STAGES-1];
    end
  end

  assign sync_data = data_sync_reg[SYNC_STAGES-1];
  assign clk_rise  = clk_sync_reg[SYNC_STAGES-1] & ~clk_d_reg;

endmodule

// File: rtl/scanner_link_receiver.sv
// scanner_link_receiver
//   Receives 8-bit LSB-first frames from the scanner link and decodes them
//   into commands (2/3/4 update the fill level, 7 announces one payload
//   frame). A stalled link aborts the partial frame or pending payload.
// Ports:
//   clk, rst     system clock, synchronous active-high reset
//   ser_clk      link clock (async), ser_data link data
//   enable       receiver enable; when low, edges are ignored
//   cmd_valid    pulse: legal command received; cmd_code holds last one
//   data_valid   pulse: payload received; data_byte holds last one
//   frame_error  pulse: timeout or illegal command code
//   fill_status  0 <80%, 1 80%, 2 90%, 3 full
//   busy         a frame or payload is in progress
module scanner_link_receiver
  import scanner_link_pkg::*;
#(
  parameter int FRAME_BITS     = 8,
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ser_clk,
  input  logic       ser_data,
  input  logic       enable,
  output logic       cmd_valid,
  output logic [7:0] cmd_code,
  output logic       data_valid,
  output logic [7:0] data_byte,
  output logic       frame_error,
  output logic [1:0] fill_status,
  output logic       busy
);

  localparam int CNT_W = $clog2(FRAME_BITS);
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_BITS - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);

  logic             sync_data;
  logic             clk_rise;
  logic             edge_seen;
  logic [7:0]       frame_word;
  logic             frame_last;
  logic             timeout_hit;

  link_state_t      state;
  logic [CNT_W-1:0] bit_cnt;
  logic [TO_W-1:0]  to_cnt;
  logic [7:0]       shreg;

  link_sync_edge #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk      (clk),
    .rst      (rst),
    .ser_clk  (ser_clk),
    .ser_data (ser_data),
    .sync_data(sync_data),
    .clk_rise (clk_rise)
  );

  assign edge_seen  = enable & clk_rise;
  // Word as it will be once the current bit is shifted in; decoding it in the
  // edge cycle lets the result pulse exactly one cycle later.
  assign frame_word = {sync_data, shreg[7:1]};
  assign frame_last = (bit_cnt == LAST_BIT);
  assign busy       = (bit_cnt != '0) || (state == S_DATA);
  // The counter's terminal step: the increment would reach TIMEOUT_CYCLES.
  // An edge in the same cycle takes priority and suppresses the abort.
  assign timeout_hit = busy && !edge_seen && (to_cnt == TO_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_CMD;
      bit_cnt     <= '0;
      to_cnt      <= '0;
      shreg       <= '0;
      cmd_valid   <= 1'b0;
      cmd_code    <= '0;
      data_valid  <= 1'b0;
      data_byte   <= '0;
      frame_error <= 1'b0;
      fill_status <= FILL_BELOW_80;
    end else begin
      cmd_valid   <= 1'b0;
      data_valid  <= 1'b0;
      frame_error <= 1'b0;
      if (!enable) begin
        state   <= S_CMD;
        bit_cnt <= '0;
        to_cnt  <= '0;
      end else if (edge_seen) begin
        to_cnt <= '0;
        shreg  <= frame_word;
        if (frame_last) begin
          bit_cnt <= '0;
          case (state)
            S_CMD: begin
              case (frame_word)
                CMD_READY_TO_TRANSFER: begin
                  cmd_valid   <= 1'b1;
                  cmd_code    <= frame_word;
                  fill_status <= FILL_80;
                end
                CMD_START_SCANNING: begin
                  cmd_valid   <= 1'b1;
                  cmd_code    <= frame_word;
                  fill_status <= FILL_90;
                end
                CMD_BUFFER_FULL: begin
                  cmd_valid   <= 1'b1;
                  cmd_code    <= frame_word;
                  fill_status <= FILL_FULL;
                end
                CMD_DATA_TRANSFER: begin
                  cmd_valid <= 1'b1;
                  cmd_code  <= frame_word;
                  state     <= S_DATA;
                end
                default: frame_error <= 1'b1;
              endcase
            end
            S_DATA: begin
              // Payload is raw data: no code check
              data_byte   <= frame_word;
              data_valid  <= 1'b1;
              fill_status <= FILL_BELOW_80;
              state       <= S_CMD;
            end
            default: state <= S_CMD;
          endcase
        end else begin
          bit_cnt <= bit_cnt + CNT_W'(1);
        end
      end else if (!busy) begin
        to_cnt <= '0;
      end else if (timeout_hit) begin
        frame_error <= 1'b1;
        bit_cnt     <= '0;
        to_cnt      <= '0;
        shreg       <= '0;
        state       <= S_CMD;
      end else begin
        to_cnt <= to_cnt + TO_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_scanner_link_receiver.sv
// tb_scanner_link_receiver
//   Directed bench for scanner_link_receiver: drives LSB-first frames at
//   clk/8 and checks decoded commands, payload, fill level, timeouts,
//   reset and enable behaviour against hand-computed values.
module tb_scanner_link_receiver;

  logic       clk;
  logic       rst;
  logic       ser_clk;
  logic       ser_data;
  logic       enable;
  logic       cmd_valid;
  logic [7:0] cmd_code;
  logic       data_valid;
  logic [7:0] data_byte;
  logic       frame_error;
  logic [1:0] fill_status;
  logic       busy;

  int checks = 0;
  int errors = 0;
  int n_cmd  = 0;
  int n_data = 0;
  int n_err  = 0;
  int n_excl = 0;
  int b_cmd, b_data, b_err, n;

  scanner_link_receiver dut (
    .clk        (clk),
    .rst        (rst),
    .ser_clk    (ser_clk),
    .ser_data   (ser_data),
    .enable     (enable),
    .cmd_valid  (cmd_valid),
    .cmd_code   (cmd_code),
    .data_valid (data_valid),
    .data_byte  (data_byte),
    .frame_error(frame_error),
    .fill_status(fill_status),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse counters, sampled on the inactive edge
  always @(negedge clk) begin
    if (cmd_valid === 1'b1)   n_cmd  <= n_cmd + 1;
    if (data_valid === 1'b1)  n_data <= n_data + 1;
    if (frame_error === 1'b1) n_err  <= n_err + 1;
    if ((int'(cmd_valid) + int'(data_valid) + int'(frame_error)) > 1)
      n_excl <= n_excl + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic snap();
    b_cmd  = n_cmd;
    b_data = n_data;
    b_err  = n_err;
  endtask

  // One link bit: data set with ser_clk low, then a rising edge; clk/8 rate
  task automatic send_bit(input logic b);
    @(negedge clk);
    ser_data = b;
    ser_clk  = 1'b0;
    repeat (4) @(negedge clk);
    ser_clk = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] f);
    for (int i = 0; i < 8; i++) send_bit(f[i]);
    @(negedge clk);
    ser_clk = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic wait_error(input string tag);
    n = 0;
    while (frame_error !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(frame_error), 32'd1);
  endtask

  initial begin
    rst      = 1'b1;
    ser_clk  = 1'b0;
    ser_data = 1'b0;
    enable   = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset state
    check("rst_cmd_valid", 32'(cmd_valid), 0);
    check("rst_cmd_code", 32'(cmd_code), 0);
    check("rst_data_valid", 32'(data_valid), 0);
    check("rst_data_byte", 32'(data_byte), 0);
    check("rst_frame_error", 32'(frame_error), 0);
    check("rst_fill", 32'(fill_status), 0);
    check("rst_busy", 32'(busy), 0);

    // Fill-level commands 2, 3, 4
    snap(); send_frame(8'h02);
    check("c2_pulses", 32'(n_cmd - b_cmd), 1);
    check("c2_code", 32'(cmd_code), 32'h02);
    check("c2_fill", 32'(fill_status), 1);
    snap(); send_frame(8'h03);
    check("c3_code", 32'(cmd_code), 32'h03);
    check("c3_fill", 32'(fill_status), 2);
    snap(); send_frame(8'h04);
    check("c4_pulses", 32'(n_cmd - b_cmd), 1);
    check("c4_code", 32'(cmd_code), 32'h04);
    check("c4_fill", 32'(fill_status), 3);
    check("c234_no_err", 32'(n_err), 0);

    // DATA_TRANSFER then payload A5
    snap(); send_frame(8'h07);
    check("c7_pulses", 32'(n_cmd - b_cmd), 1);
    check("c7_code", 32'(cmd_code), 32'h07);
    check("c7_busy_between", 32'(busy), 1);
    snap(); send_frame(8'hA5);
    check("pay_pulses", 32'(n_data - b_data), 1);
    check("pay_no_cmd", 32'(n_cmd - b_cmd), 0);
    check("pay_byte", 32'(data_byte), 32'hA5);
    check("pay_fill", 32'(fill_status), 0);
    check("pay_busy", 32'(busy), 0);

    // Illegal code keeps held outputs
    send_frame(8'h03);
    snap(); send_frame(8'h05);
    check("ill_err_pulses", 32'(n_err - b_err), 1);
    check("ill_no_cmd", 32'(n_cmd - b_cmd), 0);
    check("ill_code_held", 32'(cmd_code), 32'h03);
    check("ill_fill_held", 32'(fill_status), 2);

    // Partial frame timeout: error at count 64 after the last edge
    snap();
    send_bit(1'b1);
    send_bit(1'b0);
    @(negedge clk);
    ser_data = 1'b1;
    ser_clk  = 1'b0;
    repeat (4) @(negedge clk);
    ser_clk = 1'b1;
    n = 0;
    while (frame_error !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("to_latency", 32'(n), 67);
    @(negedge clk);
    check("to_pulse_width", 32'(frame_error), 0);
    check("to_busy_drop", 32'(busy), 0);
    check("to_err_pulses", 32'(n_err - b_err), 1);

    // Edge landing exactly on the terminal count wins
    ser_clk = 1'b0;
    repeat (4) @(negedge clk);
    snap();
    send_bit(1'b1);
    send_bit(1'b1);
    @(negedge clk);
    ser_data = 1'b0;
    ser_clk  = 1'b0;
    repeat (4) @(negedge clk);
    ser_clk = 1'b1;
    repeat (10) @(negedge clk);
    ser_clk = 1'b0;
    repeat (54) @(negedge clk);
    ser_clk = 1'b1;
    repeat (6) @(negedge clk);
    check("edge64_no_err", 32'(n_err - b_err), 0);
    check("edge64_busy", 32'(busy), 1);
    wait_error("edge64_recover_to");
    ser_clk = 1'b0;
    repeat (4) @(negedge clk);
    snap(); send_frame(8'h02);
    check("post_to_code", 32'(cmd_code), 32'h02);
    check("post_to_fill", 32'(fill_status), 1);
    check("post_to_no_err", 32'(n_err - b_err), 0);

    // DATA_TRANSFER without payload
    snap(); send_frame(8'h07);
    check("nopay_busy", 32'(busy), 1);
    wait_error("nopay_to");
    @(negedge clk);
    check("nopay_no_data", 32'(n_data - b_data), 0);
    check("nopay_busy_drop", 32'(busy), 0);
    check("nopay_fill", 32'(fill_status), 1);

    // Reset at bit 5 of a payload
    send_frame(8'h07);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0); send_bit(1'b0);
    @(negedge clk);
    ser_clk = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("mrst_cmd_code", 32'(cmd_code), 0);
    check("mrst_data_byte", 32'(data_byte), 0);
    check("mrst_fill", 32'(fill_status), 0);
    check("mrst_busy", 32'(busy), 0);
    snap(); send_frame(8'h03);
    check("mrst_next_code", 32'(cmd_code), 32'h03);
    check("mrst_next_fill", 32'(fill_status), 2);
    check("mrst_next_no_data", 32'(n_data - b_data), 0);

    // Enable dropped mid-frame
    send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
    @(negedge clk);
    enable = 1'b0;
    snap(); send_frame(8'h02);
    check("dis_no_pulses", 32'((n_cmd - b_cmd) + (n_data - b_data) + (n_err - b_err)), 0);
    check("dis_busy", 32'(busy), 0);
    check("dis_code_held", 32'(cmd_code), 32'h03);
    check("dis_fill_held", 32'(fill_status), 2);
    enable = 1'b1;
    repeat (2) @(negedge clk);
    snap(); send_frame(8'h04);
    check("reen_pulses", 32'(n_cmd - b_cmd), 1);
    check("reen_code", 32'(cmd_code), 32'h04);
    check("reen_fill", 32'(fill_status), 3);

    check("pulse_exclusive", 32'(n_excl), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/scanner_link_receiver.md
Name: scanner_link_receiver

Overview:
Downstream stage of the scanner serial output. Consumes the scanner's source-synchronous link (ser_clk/ser_data, 8-bit frames, LSB first) in the system clk domain. Decodes command frames: 2 = READY_TO_TRANSFER (80%), 3 = START_SCANNING (90%), 4 = BUFFER_FULL (100%), 7 = DATA_TRANSFER. A DATA_TRANSFER command is followed by one payload frame. Presents commands, payload and a tracked fill status to the output driver / host logic.

Parameters:
FRAME_BITS, 8, bits per frame; the bit counter is $clog2(FRAME_BITS) wide.
SYNC_STAGES, 2, flip-flop stages on ser_clk and on ser_data; minimum 2.
TIMEOUT_CYCLES, 64, clk cycles without a ser_clk rising edge before a partial frame or pending payload is aborted.

Ports:
clk  in  1  system clock.
rst  in  1  synchronous, active-high reset.
ser_clk  in  1  link clock from the scanner; asynchronous to clk; maximum rate clk/4.
ser_data  in  1  link data; valid at ser_clk rising edge.
enable  in  1  receiver enable.
cmd_valid  out  1  one-cycle pulse; a legal command frame was received.
cmd_code  out  8  last legal command code; held between pulses.
data_valid  out  1  one-cycle pulse; a payload frame was received.
data_byte  out  8  last payload byte; held between pulses.
frame_error  out  1  one-cycle pulse on timeout or on an illegal command code.
fill_status  out  2  scanner fill level: 0 = below 80%, 1 = 80%, 2 = 90%, 3 = full.
busy  out  1  high when bit_cnt != 0 or state == S_DATA.

Behaviour:
- Reset values: all outputs 0; synchronizers 0; state S_CMD; bit_cnt 0; timeout counter 0.
- Input capture:
  - ser_clk and ser_data each pass through SYNC_STAGES flops.
  - A rising edge is sync_clk & ~sync_clk_d.
  - On an edge, the synchronized data bit is shifted in LSB first: shreg <= {bit, shreg[7:1]}.
  - Pin-to-edge-detect latency is SYNC_STAGES+1 cycles.
- Frame completion: an edge with bit_cnt == FRAME_BITS-1 completes the frame. The result pulses the cycle after that edge-detect cycle. bit_cnt wraps to 0.
- FSM states: S_CMD, S_DATA.
  - S_CMD, code in {2,3,4}: pulse cmd_valid; load cmd_code; set fill_status to 1, 2 or 3 respectively; stay in S_CMD.
  - S_CMD, code 7: pulse cmd_valid; cmd_code = 7; go to S_DATA.
  - S_CMD, any other code: pulse frame_error; cmd_code and fill_status unchanged; stay in S_CMD.
  - S_DATA: the completed frame loads data_byte and pulses data_valid; fill_status returns to 0; go to S_CMD. No code checking is done on payload.
- Timeout:
  - The counter increments every cycle while busy and no edge occurs. An edge clears it. When not busy it is held at 0.
  - When the counter reaches TIMEOUT_CYCLES: pulse frame_error, clear bit_cnt, go to S_CMD, discard the partial shreg.
  - An edge in the same cycle as the terminal count wins: no error, and the counter clears.
- enable = 0: bit_cnt, timeout counter and state are forced to S_CMD/0, and edges are ignored. Held outputs (cmd_code, data_byte, fill_status) keep their values and no pulses are produced. Re-enabling mid-frame resynchronizes only at the next frame start; frame alignment is the link's responsibility.
- cmd_valid, data_valid and frame_error are mutually exclusive in any cycle.
- rst mid-frame: everything returns to reset values next cycle; any partially received frame is lost.

Decomposition:
- Shared package scanner_link_pkg holds:
  - command constants CMD_READY_TO_TRANSFER = 8'd2, CMD_START_SCANNING = 8'd3, CMD_BUFFER_FULL = 8'd4, CMD_DATA_TRANSFER = 8'd7;
  - fill_status encodings;
  - the state enum.
- The scanner transmitter uses the same package.
- One sub-module: link_sync_edge, parameterized by SYNC_STAGES. It outputs the synchronized data and a one-cycle ser_clk rising-edge strobe.

Test Plan:
- Frame 8'h02 then 8'h03 then 8'h04, LSB first at clk/8 → cmd_valid pulses with cmd_code 2, 3, 4; fill_status steps 1→2→3; no frame_error.
- Frame 8'h07 then payload 8'hA5 → cmd_valid (code 7); busy stays high between frames; data_valid pulses with data_byte = 8'hA5; fill_status = 0; state back to S_CMD.
- Frame 8'h05 → frame_error single pulse; no cmd_valid; cmd_code and fill_status retain prior values.
- 3 bits then ser_clk idle for 64 cycles → frame_error exactly at count 64; busy drops. A subsequent clean 8'h02 frame decodes correctly. Also check an edge landing on cycle 64 produces no error.
- Frame 8'h07, then no payload for 64 cycles → frame_error, return to S_CMD, no data_valid.
- Reset asserted at bit 5 of a payload, and enable dropped mid-frame → all outputs 0 after reset; no pulses while enable = 0; next full frame decodes normally.
